calendar_core: RTL and testbench

//  Parametrised date engine for the world-clock top level: day/month/year counters with leap-year logic.

---
 rtl/calendar_pkg.sv | 25 ++
 rtl/calendar_leap.sv | 20 ++
 rtl/calendar_core.sv | 140 ++++++++++++++
 tb/tb_calendar_core.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared types and month-length helper for the calendar date engine.
package calendar_pkg;

  typedef enum logic [3:0] {
    JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4,
    MAY = 4'd5, JUN = 4'd6, JUL = 4'd7, AUG = 4'd8,
    SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
  } month_t;

  typedef enum logic [1:0] {
    ADJ_DAY   = 2'd0,
    ADJ_MONTH = 2'd1,
    ADJ_YEAR  = 2'd2,
    ADJ_NONE  = 2'd3
  } adj_field_t;

  function automatic logic [4:0] days_in_month(input month_t m, input logic leap);
    case (m)
      FEB:               return leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: return 5'd30;
      default:           return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/calendar_leap.sv
// Year -> leap-year flag. Full Gregorian century rule when CALENDAR_CENTURY_RULE_EN
// is defined; otherwise the divisible-by-4 rule (exact for 1901..2099).
module calendar_leap #(
  parameter int YEAR_W = 12
) (
  input  logic [YEAR_W-1:0] year,
  output logic              leap_year
);

`ifdef CALENDAR_CENTURY_RULE_EN
  logic [31:0] year_ext;

  assign year_ext  = 32'(year);
  assign leap_year = (((year_ext % 32'd4) == 32'd0) && ((year_ext % 32'd100) != 32'd0))
                   || ((year_ext % 32'd400) == 32'd0);
`else
  assign leap_year = ((year & YEAR_W'(3)) == '0);
`endif

endmodule

// File: rtl/calendar_core.sv
// Day/month/year counters advanced by day_tick, with field adjust, day clamping
// and a one-deep pending tick. Leap rule selected by CALENDAR_CENTURY_RULE_EN.
module calendar_core
  import calendar_pkg::*;
#(
  parameter int YEAR_W     = 12,
  parameter int YEAR_MIN   = 2000,
  parameter int YEAR_MAX   = 2099,
  parameter int YEAR_RESET = 2025
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              day_tick,
  input  logic              adj_inc,
  input  logic              adj_dec,
  input  logic [1:0]        adj_sel,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [4:0]        max_day,
  output logic              leap_year,
  output logic              end_of_month,
  output logic              end_of_year
);

  localparam logic [YEAR_W-1:0] Y_MIN   = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX   = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_RESET = YEAR_W'(YEAR_RESET);

  logic [4:0]        day_r, day_n;
  month_t            month_r, month_n;
  logic [YEAR_W-1:0] year_r, year_n;
  logic              pending_r, pending_n;
  logic              eom_r, eom_n;
  logic              eoy_r, eoy_n;

  logic              adj_valid;
  adj_field_t        field;
  logic [YEAR_W-1:0] year_inc, year_dec, year_adj;
  month_t            month_adj;
  logic              adj_leap;
  logic [4:0]        clamp_lim;

  calendar_leap #(.YEAR_W(YEAR_W)) u_leap (
    .year      (year_r),
    .leap_year (leap_year)
  );

  // Leap flag of the candidate year, so a year adjust can clamp Feb 29 in the same edge.
  calendar_leap #(.YEAR_W(YEAR_W)) u_leap_adj (
    .year      (year_adj),
    .leap_year (adj_leap)
  );

  assign max_day   = days_in_month(month_r, leap_year);
  assign field     = adj_field_t'(adj_sel);
  assign adj_valid = (adj_inc ^ adj_dec) && (field != ADJ_NONE);

  assign year_inc  = (year_r == Y_MAX) ? Y_MIN : year_r + YEAR_W'(1);
  assign year_dec  = (year_r == Y_MIN) ? Y_MAX : year_r - YEAR_W'(1);
  assign year_adj  = adj_inc ? year_inc : year_dec;

  always_comb begin
    month_adj = month_r;
    if (adj_inc) month_adj = (month_r == DEC) ? JAN : month_t'(month_r + 4'd1);
    else         month_adj = (month_r == JAN) ? DEC : month_t'(month_r - 4'd1);
  end

  always_comb begin
    day_n     = day_r;
    month_n   = month_r;
    year_n    = year_r;
    pending_n = pending_r;
    eom_n     = 1'b0;
    eoy_n     = 1'b0;
    clamp_lim = max_day;

    if (adj_valid) begin
      // A tick colliding with an adjust is parked; one already parked absorbs it.
      pending_n = pending_r | day_tick;
      case (field)
        ADJ_DAY: begin
          if (adj_inc) day_n = (day_r >= max_day) ? 5'd1 : day_r + 5'd1;
          else         day_n = (day_r == 5'd1) ? max_day : day_r - 5'd1;
        end
        ADJ_MONTH: begin
          month_n   = month_adj;
          clamp_lim = days_in_month(month_adj, leap_year);
          day_n     = (day_r > clamp_lim) ? clamp_lim : day_r;
        end
        ADJ_YEAR: begin
          year_n    = year_adj;
          clamp_lim = days_in_month(month_r, adj_leap);
          day_n     = (day_r > clamp_lim) ? clamp_lim : day_r;
        end
        default: ;
      endcase
    end else if (day_tick || pending_r) begin
      pending_n = 1'b0;
      if (day_r < max_day) begin
        day_n = day_r + 5'd1;
      end else begin
        day_n = 5'd1;
        eom_n = 1'b1;
        if (month_r == DEC) begin
          month_n = JAN;
          year_n  = year_inc;
          eoy_n   = 1'b1;
        end else begin
          month_n = month_t'(month_r + 4'd1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      day_r     <= 5'd1;
      month_r   <= JAN;
      year_r    <= Y_RESET;
      pending_r <= 1'b0;
      eom_r     <= 1'b0;
      eoy_r     <= 1'b0;
    end else begin
      day_r     <= day_n;
      month_r   <= month_n;
      year_r    <= year_n;
      pending_r <= pending_n;
      eom_r     <= eom_n;
      eoy_r     <= eoy_n;
    end
  end

  assign day          = day_r;
  assign month        = month_r;
  assign year         = year_r;
  assign end_of_month = eom_r;
  assign end_of_year  = eoy_r;

endmodule

// File: tb/tb_calendar_core.sv
// Self-checking bench for calendar_core: table vectors, directed corner sequences
// and random stimulus against a date-arithmetic model (two instances, YEAR_MAX 2099/2199).
module tb_calendar_core;

  localparam int YMIN = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       day_tick = 1'b0, adj_inc = 1'b0, adj_dec = 1'b0;
  logic [1:0] adj_sel = 2'd3;

  logic [4:0]  o_day[2];
  logic [3:0]  o_month[2];
  logic [11:0] o_year[2];
  logic [4:0]  o_max[2];
  logic        o_leap[2], o_eom[2], o_eoy[2];

  int n_checks = 0;
  int n_fail   = 0;

  int md[2], mm[2], my[2], mp[2], meom[2], meoy[2];
  int ymax[2] = '{2099, 2199};

  always #5 clock = ~clock;

  calendar_core dut (
    .clock(clock), .reset(reset), .day_tick(day_tick), .adj_inc(adj_inc), .adj_dec(adj_dec),
    .adj_sel(adj_sel), .day(o_day[0]), .month(o_month[0]), .year(o_year[0]), .max_day(o_max[0]),
    .leap_year(o_leap[0]), .end_of_month(o_eom[0]), .end_of_year(o_eoy[0])
  );

  calendar_core #(.YEAR_MAX(2199)) dut_c (
    .clock(clock), .reset(reset), .day_tick(day_tick), .adj_inc(adj_inc), .adj_dec(adj_dec),
    .adj_sel(adj_sel), .day(o_day[1]), .month(o_month[1]), .year(o_year[1]), .max_day(o_max[1]),
    .leap_year(o_leap[1]), .end_of_month(o_eom[1]), .end_of_year(o_eoy[1])
  );

  function automatic int is_leap(int y);
`ifdef CALENDAR_CENTURY_RULE_EN
    return (((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0) ? 1 : 0;
`else
    return ((y % 4) == 0) ? 1 : 0;
`endif
  endfunction

  function automatic int dim(int m, int y);
    if (m == 2) return 28 + is_leap(y);
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      md[k] = 1; mm[k] = 1; my[k] = 2025; mp[k] = 0; meom[k] = 0; meoy[k] = 0;
    end
  endtask

  task automatic model_step(input bit t, input bit i, input bit d, input int s);
    for (int k = 0; k < 2; k++) begin
      bit valid;
      valid   = (i != d) && (s != 3);
      meom[k] = 0;
      meoy[k] = 0;
      if (valid) begin
        if (t) mp[k] = 1;
        if (s == 0) begin
          md[k] = i ? (md[k] % dim(mm[k], my[k])) + 1 : ((md[k] == 1) ? dim(mm[k], my[k]) : md[k] - 1);
        end else begin
          if (s == 1) mm[k] = i ? (mm[k] % 12) + 1 : ((mm[k] + 10) % 12) + 1;
          else my[k] = i ? ((my[k] == ymax[k]) ? YMIN : my[k] + 1) : ((my[k] == YMIN) ? ymax[k] : my[k] - 1);
          if (md[k] > dim(mm[k], my[k])) md[k] = dim(mm[k], my[k]);
        end
      end else if (t || mp[k] != 0) begin
        mp[k] = 0;
        md[k]++;
        if (md[k] > dim(mm[k], my[k])) begin
          md[k] = 1; meom[k] = 1; mm[k]++;
          if (mm[k] > 12) begin
            mm[k] = 1; meoy[k] = 1;
            my[k] = (my[k] == ymax[k]) ? YMIN : my[k] + 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      string p;
      p = (k == 0) ? "u0" : "u1";
      check({p, "_day"},   32'(o_day[k]),   32'(md[k]));
      check({p, "_month"}, 32'(o_month[k]), 32'(mm[k]));
      check({p, "_year"},  32'(o_year[k]),  32'(my[k]));
      check({p, "_maxday"}, 32'(o_max[k]),  32'(dim(mm[k], my[k])));
      check({p, "_leap"},  32'(o_leap[k]),  32'(is_leap(my[k])));
      check({p, "_eom"},   32'(o_eom[k]),   32'(meom[k]));
      check({p, "_eoy"},   32'(o_eoy[k]),   32'(meoy[k]));
    end
  endtask

  task automatic do_cycle(input bit t, input bit i, input bit d, input int s);
    @(negedge clock);
    day_tick = t; adj_inc = i; adj_dec = d; adj_sel = 2'(s);
    @(posedge clock);
    model_step(t, i, d, s);
    #1;
    compare_all();
  endtask

  task automatic goto_date(input int k, input int d, input int m, input int y);
    int n;
    do_cycle(0, 0, 0, 3);
    n = 0;
    while (my[k] != y && n < 250) begin do_cycle(0, y > my[k], y < my[k], 2); n++; end
    n = 0;
    while (mm[k] != m && n < 12) begin do_cycle(0, m > mm[k], m < mm[k], 1); n++; end
    n = 0;
    while (md[k] != d && n < 31) begin do_cycle(0, d > md[k], d < md[k], 0); n++; end
  endtask

  task automatic chk_date(input string name, input int k, input int d, input int m, input int y,
                          input int eom, input int eoy);
    check({name, "_day"},   32'(o_day[k]),   32'(d));
    check({name, "_month"}, 32'(o_month[k]), 32'(m));
    check({name, "_year"},  32'(o_year[k]),  32'(y));
    check({name, "_eom"},   32'(o_eom[k]),   32'(eom));
    check({name, "_eoy"},   32'(o_eoy[k]),   32'(eoy));
  endtask

  typedef struct {
    int sd, sm, sy;
    bit t, i, d;
    int s;
    int ed, em, ey, emax, eleap, eeom, eeoy;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{28, 2, 2024, 1, 0, 0, 3, 29, 2, 2024, 29, 1, 0, 0};
    vecs[1]  = '{29, 2, 2024, 1, 0, 0, 3,  1, 3, 2024, 31, 1, 1, 0};
    vecs[2]  = '{28, 2, 2025, 1, 0, 0, 3,  1, 3, 2025, 31, 0, 1, 0};
    vecs[3]  = '{31, 12, 2099, 1, 0, 0, 3, 1, 1, 2000, 31, 1, 1, 1};
    vecs[4]  = '{31, 3, 2024, 0, 0, 1, 1, 29, 2, 2024, 29, 1, 0, 0};
    vecs[5]  = '{29, 2, 2024, 0, 1, 0, 2, 28, 2, 2025, 28, 0, 0, 0};
    vecs[6]  = '{30, 4, 2025, 0, 1, 0, 0,  1, 4, 2025, 30, 0, 0, 0};
    vecs[7]  = '{ 1, 4, 2025, 0, 0, 1, 0, 30, 4, 2025, 30, 0, 0, 0};
    vecs[8]  = '{15, 12, 2025, 0, 1, 0, 1, 15, 1, 2025, 31, 0, 0, 0};
    vecs[9]  = '{10, 6, 2000, 0, 0, 1, 2, 10, 6, 2099, 30, 0, 0, 0};
    vecs[10] = '{ 5, 5, 2025, 1, 1, 1, 0,  6, 5, 2025, 31, 0, 0, 0};
    vecs[11] = '{ 5, 5, 2025, 1, 1, 0, 3,  6, 5, 2025, 31, 0, 0, 0};
    vecs[12] = '{31, 1, 2025, 0, 1, 0, 1, 28, 2, 2025, 28, 0, 0, 0};
    vecs[13] = '{ 4, 7, 2099, 0, 1, 0, 2,  4, 7, 2000, 31, 1, 0, 0};
    vecs[14] = '{30, 6, 2025, 1, 0, 0, 3,  1, 7, 2025, 31, 0, 1, 0};
    vecs[15] = '{ 1, 1, 2025, 0, 0, 1, 1,  1, 12, 2025, 31, 0, 0, 0};

    // Reset state
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    chk_date("reset", 0, 1, 1, 2025, 0, 0);
    check("reset_maxday", 32'(o_max[0]), 32'd31);
    @(negedge clock);
    reset = 1'b0;

    // Table vectors on the YEAR_MAX=2099 instance
    for (int v = 0; v < 16; v++) begin
      goto_date(0, vecs[v].sd, vecs[v].sm, vecs[v].sy);
      do_cycle(vecs[v].t, vecs[v].i, vecs[v].d, vecs[v].s);
      chk_date($sformatf("vec%0d", v), 0, vecs[v].ed, vecs[v].em, vecs[v].ey, vecs[v].eeom, vecs[v].eeoy);
      check($sformatf("vec%0d_maxday", v), 32'(o_max[0]), 32'(vecs[v].emax));
      check($sformatf("vec%0d_leap", v), 32'(o_leap[0]), 32'(vecs[v].eleap));
    end

    // Year rollover pulses last exactly one cycle
    goto_date(0, 31, 12, 2099);
    do_cycle(1, 0, 0, 3);
    chk_date("yr_roll", 0, 1, 1, 2000, 1, 1);
    do_cycle(0, 0, 0, 3);
    chk_date("yr_roll_next", 0, 1, 1, 2000, 0, 0);

    // Tick colliding with adjust is applied one cycle later
    goto_date(0, 15, 1, 2025);
    do_cycle(1, 1, 0, 0);
    chk_date("collide", 0, 16, 1, 2025, 0, 0);
    do_cycle(0, 0, 0, 3);
    chk_date("collide_pend", 0, 17, 1, 2025, 0, 0);
    do_cycle(0, 0, 0, 3);
    chk_date("collide_idle", 0, 17, 1, 2025, 0, 0);

    // Second colliding tick while pending is dropped
    do_cycle(1, 1, 0, 0);
    do_cycle(1, 1, 0, 0);
    chk_date("drop_adj", 0, 19, 1, 2025, 0, 0);
    do_cycle(0, 0, 0, 3);
    chk_date("drop_pend", 0, 20, 1, 2025, 0, 0);
    do_cycle(0, 0, 0, 3);
    chk_date("drop_idle", 0, 20, 1, 2025, 0, 0);

    // Century year 2100 on the YEAR_MAX=2199 instance
    goto_date(1, 28, 2, 2100);
    do_cycle(1, 0, 0, 3);
`ifdef CALENDAR_CENTURY_RULE_EN
    chk_date("y2100", 1, 1, 3, 2100, 1, 0);
    check("y2100_leap", 32'(o_leap[1]), 32'd0);
`else
    chk_date("y2100", 1, 29, 2, 2100, 0, 0);
    check("y2100_leap", 32'(o_leap[1]), 32'd1);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      bit t, i, d;
      r = int'($urandom_range(0, 9));
      t = ($urandom_range(0, 2) == 0);
      i = (r < 2) || (r == 3);
      d = (r == 2) || (r == 3);
      do_cycle(t, i, d, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while a month-rollover pulse is high
    goto_date(0, 31, 1, 2025);
    do_cycle(1, 0, 0, 3);
    chk_date("pre_rst", 0, 1, 2, 2025, 1, 0);
    day_tick = 1'b0; adj_inc = 1'b0; adj_dec = 1'b0; adj_sel = 2'd3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk_date("async_rst", 0, 1, 1, 2025, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset clears a pending tick
    do_cycle(1, 1, 0, 0);
    chk_date("pend_set", 0, 2, 1, 2025, 0, 0);
    day_tick = 1'b0; adj_inc = 1'b0; adj_dec = 1'b0; adj_sel = 2'd3;
    reset = 1'b1;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    do_cycle(0, 0, 0, 3);
    chk_date("pend_clr", 0, 1, 1, 2025, 0, 0);
    do_cycle(0, 0, 0, 3);
    chk_date("pend_clr2", 0, 1, 1, 2025, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
